micro_sequencer: RTL

Next-state generator for the multicycle CPU's microprogrammed control unit. Each cycle it reads the 2-bit AddrCtl field of the current microinstruction and the IR opcode, then registers the next control state. That state is the address into the microinstruction ROM, so this block closes the loop between the ROM and the datapath. It also tracks retired instructions and flags undecodable opcodes.

---
 rtl/cpu_ctrl_pkg.sv | 34 +++
 rtl/dispatch_rom.sv | 41 ++++
 rtl/micro_sequencer.sv | 79 +++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multicycle CPU control unit: control-state (ROM address)
// map, MIPS opcodes decoded by the dispatch tables, and AddrCtl encodings.
package cpu_ctrl_pkg;

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_LW_READ   = 4'd3;
   localparam logic [3:0] S_LW_WB     = 4'd4;
   localparam logic [3:0] S_SW_WRITE  = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_DONE    = 4'd7;
   localparam logic [3:0] S_BEQ       = 4'd8;
   localparam logic [3:0] S_J         = 4'd9;
   localparam logic [3:0] S_ADDI_EXEC = 4'd10;
   localparam logic [3:0] S_I_WB      = 4'd11;
   localparam logic [3:0] S_BNE       = 4'd12;
   localparam logic [3:0] S_ANDI_EXEC = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;

   localparam logic [1:0] AC_FETCH = 2'b00;
   localparam logic [1:0] AC_DISP1 = 2'b01;
   localparam logic [1:0] AC_DISP2 = 2'b10;
   localparam logic [1:0] AC_SEQ   = 2'b11;

endpackage

// File: rtl/dispatch_rom.sv
// Opcode-indexed dispatch tables used by the micro-sequencer. Purely combinational;
// a *_valid of 0 marks an opcode the table cannot decode.
module dispatch_rom
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   output logic [3:0] o_disp1_state,
   output logic       o_disp1_valid,
   output logic [3:0] o_disp2_state,
   output logic       o_disp2_valid
);

   // Table 1: decode -> first execution state of each instruction class
   always_comb begin
      o_disp1_state = S_FETCH;
      o_disp1_valid = 1'b1;
      case (i_opcode)
         OP_RTYPE:     o_disp1_state = S_R_EXEC;
         OP_LW, OP_SW: o_disp1_state = S_MEM_ADDR;
         OP_BEQ:       o_disp1_state = S_BEQ;
         OP_BNE:       o_disp1_state = S_BNE;
         OP_J:         o_disp1_state = S_J;
         OP_ADDI:      o_disp1_state = S_ADDI_EXEC;
         OP_ANDI:      o_disp1_state = S_ANDI_EXEC;
         default:      o_disp1_valid = 1'b0;
      endcase
   end

   // Table 2: second-level split (load vs store, andi writeback)
   always_comb begin
      o_disp2_state = S_FETCH;
      o_disp2_valid = 1'b1;
      case (i_opcode)
         OP_LW:   o_disp2_state = S_LW_READ;
         OP_SW:   o_disp2_state = S_SW_WRITE;
         OP_ANDI: o_disp2_state = S_I_WB;
         default: o_disp2_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// Next-state generator for the microprogrammed control unit: registers the next
// ROM address from AddrCtl/opcode, counts retired instructions, flags bad opcodes.
module micro_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [1:0]  i_addr_ctl,
   input  logic [5:0]  i_opcode,
   input  logic        i_stall,
   output logic [3:0]  o_state,
   output logic        o_instr_done,
   output logic        o_illegal_op,
   output logic [15:0] o_retired_count
);

   logic [3:0]  r_state;
   logic        r_instr_done;
   logic        r_illegal_op;
   logic [15:0] r_retired_count;

   logic [3:0]  w_disp1_state;
   logic        w_disp1_valid;
   logic [3:0]  w_disp2_state;
   logic        w_disp2_valid;
   logic [3:0]  w_next_state;
   logic        w_miss;
   logic        w_retire;

   dispatch_rom u_dispatch_rom (
      .i_opcode      (i_opcode),
      .o_disp1_state (w_disp1_state),
      .o_disp1_valid (w_disp1_valid),
      .o_disp2_state (w_disp2_state),
      .o_disp2_valid (w_disp2_valid)
   );

   always_comb begin
      w_next_state = S_FETCH;
      w_miss       = 1'b0;
      case (i_addr_ctl)
         AC_FETCH: w_next_state = S_FETCH;
         AC_DISP1: begin
            if (w_disp1_valid) w_next_state = w_disp1_state;
            else               w_miss       = 1'b1;
         end
         AC_DISP2: begin
            if (w_disp2_valid) w_next_state = w_disp2_state;
            else               w_miss       = 1'b1;
         end
         default:  w_next_state = r_state + 4'd1;
      endcase
   end

   // A dispatch miss also lands in fetch, but it aborts rather than retires
   assign w_retire = (r_state != S_FETCH) && (w_next_state == S_FETCH) && !w_miss;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state         <= S_FETCH;
         r_instr_done    <= 1'b0;
         r_illegal_op    <= 1'b0;
         r_retired_count <= 16'd0;
      end else if (i_stall) begin
         r_instr_done    <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_instr_done    <= w_retire;
         r_illegal_op    <= r_illegal_op | w_miss;
         r_retired_count <= r_retired_count + {15'd0, w_retire};
      end
   end

   assign o_state         = r_state;
   assign o_instr_done    = r_instr_done;
   assign o_illegal_op    = r_illegal_op;
   assign o_retired_count = r_retired_count;

endmodule
